// File: rtl/cskipa_pipe.sv
// Pipelined carry-skip adder/subtractor: BLOCK-bit skip groups, BLOCKS_PER_STAGE groups per stage,
// valid/ready handshake with full backpressure.
module cskipa_pipe #(
  parameter int unsigned WIDTH            = 36,
  parameter int unsigned BLOCK            = 4,
  parameter int unsigned BLOCKS_PER_STAGE = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int unsigned BLK  = (BLOCK == 0) ? 1 : BLOCK;
  localparam int unsigned BPS  = (BLOCKS_PER_STAGE == 0) ? 1 : BLOCKS_PER_STAGE;
  localparam int unsigned NGRP = WIDTH / BLK;
  localparam int unsigned NSTG = (NGRP + BPS - 1) / BPS;

  if (BLOCK == 0 || BLOCKS_PER_STAGE == 0 || (WIDTH % BLK) != 0) begin : g_param_err
    $error("cskipa_pipe: WIDTH must be a multiple of BLOCK, BLOCK>=1, BLOCKS_PER_STAGE>=1");
  end

  logic             r_vld [NSTG];
  logic [WIDTH-1:0] r_a   [NSTG];
  logic [WIDTH-1:0] r_b   [NSTG];
  logic [WIDTH-1:0] r_sum [NSTG];
  logic             r_c   [NSTG];
  logic             r_ovf;

  logic             w_vld_in  [NSTG];
  logic [WIDTH-1:0] w_a_in    [NSTG];
  logic [WIDTH-1:0] w_b_in    [NSTG];
  logic [WIDTH-1:0] w_sum_in  [NSTG];
  logic             w_c_in    [NSTG];
  logic [WIDTH-1:0] w_sum_nxt [NSTG];
  logic             w_c_nxt   [NSTG];
  logic             w_ovf_nxt;
  logic [NSTG-1:0]  w_adv;

  // Stage 0 takes the token straight from the ports; B is pre-inverted for subtraction.
  for (genvar k = 0; k < NSTG; k++) begin : g_stage_in
    if (k == 0) begin : g_first
      assign w_vld_in[k] = i_valid;
      assign w_a_in[k]   = i_add_term1;
      assign w_b_in[k]   = i_sub ? ~i_add_term2 : i_add_term2;
      assign w_c_in[k]   = i_sub | i_cin;
      assign w_sum_in[k] = '0;
    end else begin : g_rest
      assign w_vld_in[k] = r_vld[k-1];
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_c_in[k]   = r_c[k-1];
      assign w_sum_in[k] = r_sum[k-1];
    end
  end

  // A stage moves when it is empty or its successor moves; the chain ends at i_ready.
  always_comb begin
    logic adv;
    adv   = i_ready;
    w_adv = '0;
    for (int k = int'(NSTG) - 1; k >= 0; k--) begin
      adv      = !r_vld[k] || adv;
      w_adv[k] = adv;
    end
  end

  assign o_ready = w_adv[0];

  always_comb begin
    logic [WIDTH-1:0] a, b, s;
    logic             c, rc, p, p_all;
    int unsigned      idx;
    a         = '0;
    b         = '0;
    s         = '0;
    c         = 1'b0;
    rc        = 1'b0;
    p         = 1'b0;
    p_all     = 1'b0;
    idx       = 0;
    w_ovf_nxt = 1'b0;
    for (int k = 0; k < int'(NSTG); k++) begin
      a = w_a_in[k];
      b = w_b_in[k];
      s = w_sum_in[k];
      c = w_c_in[k];
      for (int j = 0; j < int'(BPS); j++) begin
        if (k * BPS + j < NGRP) begin
          rc    = c;
          p_all = 1'b1;
          for (int i = 0; i < int'(BLK); i++) begin
            idx    = (k * BPS + j) * BLK + i;
            p      = a[idx] ^ b[idx];
            s[idx] = p ^ rc;
            rc     = (a[idx] & b[idx]) | (p & rc);
            p_all  = p_all & p;
          end
          // Skip mux: a fully propagating group passes its carry-in through.
          c = p_all ? c : rc;
        end
      end
      w_sum_nxt[k] = s;
      w_c_nxt[k]   = c;
      if (k == int'(NSTG) - 1) begin
        w_ovf_nxt = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(NSTG); k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NSTG); k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= w_vld_in[k];
          r_a[k]   <= w_a_in[k];
          r_b[k]   <= w_b_in[k];
          r_sum[k] <= w_sum_nxt[k];
          r_c[k]   <= w_c_nxt[k];
        end
      end
      if (w_adv[NSTG-1]) begin
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  assign o_valid    = r_vld[NSTG-1];
  assign o_sum      = r_sum[NSTG-1];
  assign o_cout     = r_c[NSTG-1];
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_cskipa_pipe.sv
// Self-checking bench for cskipa_pipe (36-bit, 4-bit groups, 3 groups/stage): directed vectors,
// streaming, backpressure, mid-flight reset and a randomised run against an A+B model.
module tb_cskipa_pipe;
  localparam int unsigned W = 36;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid, o_ready, i_cin, i_sub, o_valid, i_ready, o_cout, o_overflow;
  logic [W-1:0] a, b, o_sum;

  always #5 clk = ~clk;

  cskipa_pipe #(
    .WIDTH           (36),
    .BLOCK           (4),
    .BLOCKS_PER_STAGE(3)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_add_term1(a),
    .i_add_term2(b),
    .i_cin      (i_cin),
    .i_sub      (i_sub),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sum      (o_sum),
    .o_cout     (o_cout),
    .o_overflow (o_overflow)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  int           n_in = 0;
  int           n_out = 0;
  logic [W+1:0] exp_q[$];
  logic         s_ov, s_rdy, s_fire_out, s_cout, s_ovf;
  logic [W-1:0] s_sum, held;
  int           lat, acc, base, first, last, cnt, guard;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {overflow, cout, sum}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                             input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         ovf;
    be  = sub ? ~tb_ : tb_;
    r   = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf = (ta[W-1] == be[W-1]) && (r[W-1] != ta[W-1]);
    return {ovf, r};
  endfunction

  // Inputs are set just after a negedge; sample 1 ns later, score, then wait for the next negedge.
  task automatic step();
    #1;
    s_ov       = o_valid;
    s_rdy      = o_ready;
    s_sum      = o_sum;
    s_cout     = o_cout;
    s_ovf      = o_overflow;
    s_fire_out = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        s_fire_out = 1'b1;
        n_out++;
        check("out_has_token", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) check("result", {o_overflow, o_cout, o_sum}, exp_q.pop_front());
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(ref_model(a, b, i_cin, i_sub));
        n_in++;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic cin, input logic sub, input logic [W-1:0] e_sum,
                          input logic e_cout, input logic e_ovf);
    a       = ta;
    b       = tb_;
    i_cin   = cin;
    i_sub   = sub;
    i_valid = 1'b1;
    i_ready = 1'b1;
    step();
    check({tag, "_ready"}, 64'(s_rdy), 64'(1));
    i_valid = 1'b0;
    lat     = 0;
    do begin
      lat++;
      step();
    end while (!s_ov && lat < 10);
    check({tag, "_latency"}, 64'(lat), 64'(3));
    check({tag, "_sum"}, 64'(s_sum), 64'(e_sum));
    check({tag, "_cout"}, 64'(s_cout), 64'(e_cout));
    check({tag, "_ovf"}, 64'(s_ovf), 64'(e_ovf));
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_cin   = 1'b0;
    i_sub   = 1'b0;
    a       = '0;
    b       = '0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_valid", 64'(s_ov), 64'(0));
    check("rst_sum", 64'(s_sum), 64'(0));
    check("rst_cout", 64'(s_cout), 64'(0));
    check("rst_ovf", 64'(s_ovf), 64'(0));
    check("rst_ready", 64'(s_rdy), 64'(1));

    // Directed vectors with hand-computed results.
    send_one("add_1_2", 36'h0_0000_0001, 36'h0_0000_0002, 1'b0, 1'b0, 36'h0_0000_0003, 1'b0, 1'b0);
    send_one("skip_chain", 36'hF_FFFF_FFFF, 36'h0_0000_0001, 1'b0, 1'b0, 36'h0, 1'b1, 1'b0);
    send_one("pos_ovf", 36'h7_FFFF_FFFF, 36'h0_0000_0001, 1'b0, 1'b0, 36'h8_0000_0000, 1'b0, 1'b1);
    send_one("sub_5_7", 36'h5, 36'h7, 1'b0, 1'b1, 36'hF_FFFF_FFFE, 1'b0, 1'b0);
    send_one("sub_7_5", 36'h7, 36'h5, 1'b0, 1'b1, 36'h2, 1'b1, 1'b0);
    send_one("sub_ovf", 36'h8_0000_0000, 36'h1, 1'b0, 1'b1, 36'h7_FFFF_FFFF, 1'b1, 1'b1);
    send_one("cin_add", 36'h0_0000_000F, 36'h0, 1'b1, 1'b0, 36'h0_0000_0010, 1'b0, 1'b0);
    send_one("sub_ign_cin", 36'h5, 36'h5, 1'b0, 1'b1, 36'h0, 1'b1, 1'b0);
    send_one("neg_ovf", 36'h8_0000_0000, 36'h8_0000_0000, 1'b1, 1'b0, 36'h0_0000_0001, 1'b1, 1'b1);

    // Back-to-back stream of 10 tokens.
    i_ready = 1'b1;
    base    = n_out;
    first   = -1;
    last    = -1;
    cnt     = 0;
    for (int t = 0; t < 16; t++) begin
      i_valid = (t < 10);
      a       = W'({$urandom(), $urandom()});
      b       = W'({$urandom(), $urandom()});
      i_cin   = 1'(t);
      i_sub   = 1'(t >> 1);
      step();
      if (s_fire_out) begin
        if (first < 0) first = t;
        last = t;
        cnt++;
      end
    end
    check("stream_count", 64'(cnt), 64'(10));
    check("stream_first", 64'(first), 64'(3));
    check("stream_contig", 64'(last - first), 64'(9));
    check("stream_empty", 64'(exp_q.size()), 64'(0));

    // Backpressure: fill with i_ready low, hold, then release.
    base    = n_out;
    acc     = 0;
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      a     = W'({$urandom(), $urandom()});
      b     = W'({$urandom(), $urandom()});
      i_sub = 1'($urandom_range(0, 1));
      step();
      if (s_rdy) acc++;
      else break;
    end
    check("stall_accepted", 64'(acc), 64'(3));
    check("stall_valid", 64'(s_ov), 64'(1));
    held = s_sum;
    for (int t = 0; t < 5; t++) begin
      step();
      check("stall_ready_low", 64'(s_rdy), 64'(0));
      check("stall_valid_hold", 64'(s_ov), 64'(1));
      check("stall_sum_stable", 64'(s_sum), 64'(held));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int t = 0; t < 6; t++) step();
    check("stall_out_count", 64'(n_out - base), 64'(3));
    check("stall_empty", 64'(exp_q.size()), 64'(0));

    // Reset with two tokens in flight.
    base    = n_out;
    i_valid = 1'b1;
    a       = 36'h1_1111_1111;
    b       = 36'h2_2222_2222;
    i_sub   = 1'b0;
    step();
    a = 36'h3_3333_3333;
    step();
    i_valid = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("midrst_valid", 64'(s_ov), 64'(0));
    check("midrst_sum", 64'(s_sum), 64'(0));
    check("midrst_ready", 64'(s_rdy), 64'(1));
    for (int t = 0; t < 8; t++) step();
    check("midrst_no_out", 64'(n_out - base), 64'(0));

    // Random run with random stalls on both sides.
    base  = n_in + 10000;
    guard = 0;
    while (n_in < base && guard < 60000) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      a       = ($urandom_range(0, 7) == 0) ? '1 : W'({$urandom(), $urandom()});
      b       = ($urandom_range(0, 7) == 0) ? W'(1) : W'({$urandom(), $urandom()});
      i_cin   = 1'($urandom_range(0, 1));
      i_sub   = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    check("rand_sent", 64'(n_in >= base), 64'(1));
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int t = 0; t < 8; t++) step();
    check("rand_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
